// File: rtl/pipe_pkg.sv
// Shared pipeline constants: bus widths, load_op encoding and EX->MEM field offsets.
package pipe_pkg;

  localparam int EX_MEM_BUS_W = 74;
  localparam int MEM_WB_BUS_W = 70;
  localparam int WB_BUS_W     = 38;

  typedef enum logic [2:0] {
    LOAD_W  = 3'b000,
    LOAD_B  = 3'b001,
    LOAD_BU = 3'b010,
    LOAD_H  = 3'b011,
    LOAD_HU = 3'b100
  } load_op_e;

  // Bit positions inside EX_to_MEM_bus (LSB of each field).
  localparam int EXM_RES_FROM_MEM = 73;
  localparam int EXM_GR_WE        = 72;
  localparam int EXM_DEST_LSB     = 67;
  localparam int EXM_LOAD_OP_LSB  = 64;
  localparam int EXM_ALU_LSB      = 32;
  localparam int EXM_PC_LSB       = 0;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: byte/halfword lane select from the SRAM word plus sign/zero extension.
module mem_load_align
  import pipe_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
    endcase
    // addr[0] is deliberately ignored for halfwords; no misalignment trap.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (load_op)
      LOAD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_BU: load_data = {24'h0, byte_sel};
      LOAD_H:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_HU: load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Optional forwarding outputs enabled by macro MEM_FWD_EN.
module mem_stage
  import pipe_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    EX_to_MEM_valid,
  input  logic [EX_MEM_BUS_W-1:0] EX_to_MEM_bus,
  output logic                    MEM_allow,
  input  logic                    WB_allow,
  input  logic [31:0]             data_sram_rdata,
  output logic                    MEM_to_WB_valid,
  output logic [MEM_WB_BUS_W-1:0] MEM_to_WB_bus,
  output logic [4:0]              MEM_dest_bus,
  output logic [31:0]             MEM_value_bus,
  output logic                    MEM_load_bus
);

  logic                    mem_valid_q, mem_valid_d;
  logic [EX_MEM_BUS_W-1:0] bus_q, bus_d;
  logic                    mem_go;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [2:0]  load_op;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] load_data;
  logic [31:0] final_result;

  // SRAM data arrives the cycle after issue, so the stage never stalls itself.
  assign mem_go          = 1'b1;
  assign MEM_allow       = !mem_valid_q || (mem_go && WB_allow);
  assign MEM_to_WB_valid = mem_valid_q && mem_go;

  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    if (MEM_allow) mem_valid_d = EX_to_MEM_valid;
    if (EX_to_MEM_valid && MEM_allow) bus_d = EX_to_MEM_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_valid_q <= 1'b0;
    else       mem_valid_q <= mem_valid_d;
  end

  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  assign res_from_mem = bus_q[EXM_RES_FROM_MEM];
  assign gr_we        = bus_q[EXM_GR_WE];
  assign dest         = bus_q[EXM_DEST_LSB    +: 5];
  assign load_op      = bus_q[EXM_LOAD_OP_LSB +: 3];
  assign alu_result   = bus_q[EXM_ALU_LSB     +: 32];
  assign pc           = bus_q[EXM_PC_LSB      +: 32];

  mem_load_align u_align (
    .load_op   (load_op),
    .addr      (alu_result[1:0]),
    .rdata     (data_sram_rdata),
    .load_data (load_data)
  );

  assign final_result  = res_from_mem ? load_data : alu_result;
  assign MEM_to_WB_bus = {gr_we, dest, final_result, pc};
  assign MEM_dest_bus  = (mem_valid_q && gr_we) ? dest : 5'd0;

`ifdef MEM_FWD_EN
  assign MEM_value_bus = final_result;
  assign MEM_load_bus  = mem_valid_q && res_from_mem;
`else
  assign MEM_value_bus = 32'd0;
  assign MEM_load_bus  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, handshake sequences, random vs. reference model.
module tb_mem_stage;
  import pipe_pkg::*;

  typedef struct {
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] rdata;
    logic [31:0] exp_result;
    logic [4:0]  exp_dest;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [73:0] ex_bus;
  logic        wb_allow;
  logic [31:0] rdata;
  logic        MEM_allow;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [4:0]  MEM_dest_bus;
  logic [31:0] MEM_value_bus;
  logic        MEM_load_bus;

  int vectors = 0;
  int miscompares = 0;

  logic   m_valid;
  instr_t m_ins;
  instr_t idle;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_MEM_valid (ex_valid),
    .EX_to_MEM_bus   (ex_bus),
    .MEM_allow       (MEM_allow),
    .WB_allow        (wb_allow),
    .data_sram_rdata (rdata),
    .MEM_to_WB_valid (MEM_to_WB_valid),
    .MEM_to_WB_bus   (MEM_to_WB_bus),
    .MEM_dest_bus    (MEM_dest_bus),
    .MEM_value_bus   (MEM_value_bus),
    .MEM_load_bus    (MEM_load_bus)
  );

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result from the architectural rules, using shifts and masks.
  function automatic logic [31:0] ref_result(input instr_t i, input logic [31:0] rd);
    logic [31:0] v;
    if (!i.rfm) return i.alu;
    case (i.op)
      3'd1, 3'd2: begin
        v = (rd >> (int'(i.alu[1:0]) * 8)) & 32'h0000_00FF;
        if (i.op == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = (rd >> (int'(i.alu[1]) * 16)) & 32'h0000_FFFF;
        if (i.op == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [73:0] pack(input instr_t i);
    return {i.rfm, i.we, i.dest, i.op, i.alu, i.pc};
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.rfm  = 1'($urandom_range(0, 1));
    i.we   = 1'($urandom_range(0, 1));
    i.dest = 5'($urandom_range(0, 31));
    i.op   = 3'($urandom_range(0, 7));
    i.alu  = $urandom;
    i.pc   = $urandom;
    return i;
  endfunction

  task automatic check_model();
    logic [31:0] fr;
    fr = ref_result(m_ins, rdata);
    chk("allow", 70'(MEM_allow), 70'(!m_valid || wb_allow));
    chk("wb_valid", 70'(MEM_to_WB_valid), 70'(m_valid));
    chk("dest_bus", 70'(MEM_dest_bus), 70'((m_valid && m_ins.we) ? m_ins.dest : 5'd0));
    if (m_valid) chk("wb_bus", MEM_to_WB_bus, {m_ins.we, m_ins.dest, fr, m_ins.pc});
`ifdef MEM_FWD_EN
    chk("load_bus", 70'(MEM_load_bus), 70'(m_valid && m_ins.rfm));
    if (m_valid) chk("value_bus", 70'(MEM_value_bus), 70'(fr));
`else
    chk("load_bus", 70'(MEM_load_bus), 70'(0));
    chk("value_bus", 70'(MEM_value_bus), 70'(0));
`endif
  endtask

  // Drive inputs mid-cycle, then compare the combinational outputs against the model.
  task automatic drive(input logic rst, input logic ev, input instr_t ni, input logic wa,
                       input logic [31:0] rd);
    @(negedge clk);
    reset    = rst;
    ex_valid = ev;
    ex_bus   = pack(ni);
    wb_allow = wa;
    rdata    = rd;
    #1;
    check_model();
  endtask

  // Clock edge: update the model from the inputs that were applied.
  task automatic advance(input instr_t ni);
    @(posedge clk);
    if (reset) m_valid = 1'b0;
    else if (!m_valid || wb_allow) begin
      m_valid = ex_valid;
      if (ex_valid) m_ins = ni;
    end
  endtask

  task automatic step(input logic rst, input logic ev, input instr_t ni, input logic wa,
                      input logic [31:0] rd);
    drive(rst, ev, ni, wa, rd);
    advance(ni);
  endtask

  vec_t   tbl[9];
  instr_t a, b, seq[4];

  initial begin
    idle = '{rfm: 0, we: 0, dest: 0, op: 0, alu: 0, pc: 0};
    m_ins = idle;
    tbl[0] = '{'{0, 1, 5'd5, 3'd0, 32'h0000_1234, 32'h1C00_0010}, 32'h80F1_7F82, 32'h0000_1234, 5'd5};
    tbl[1] = '{'{1, 1, 5'd3, 3'd1, 32'h1000_0000, 32'h1C00_0020}, 32'h80F1_7F82, 32'hFFFF_FF82, 5'd3};
    tbl[2] = '{'{1, 1, 5'd4, 3'd2, 32'h1000_0003, 32'h1C00_0024}, 32'h80F1_7F82, 32'h0000_0080, 5'd4};
    tbl[3] = '{'{1, 1, 5'd6, 3'd3, 32'h1000_0002, 32'h1C00_0028}, 32'h80F1_7F82, 32'hFFFF_80F1, 5'd6};
    tbl[4] = '{'{1, 1, 5'd8, 3'd4, 32'h1000_0000, 32'h1C00_002C}, 32'h80F1_7F82, 32'h0000_7F82, 5'd8};
    tbl[5] = '{'{1, 1, 5'd9, 3'd0, 32'h1000_0004, 32'h1C00_0030}, 32'h80F1_7F82, 32'h80F1_7F82, 5'd9};
    tbl[6] = '{'{1, 1, 5'd10, 3'd3, 32'h1000_0003, 32'h1C00_0034}, 32'h80F1_7F82, 32'hFFFF_80F1, 5'd10};
    tbl[7] = '{'{1, 1, 5'd11, 3'd7, 32'h1000_0001, 32'h1C00_0038}, 32'h80F1_7F82, 32'h80F1_7F82, 5'd11};
    tbl[8] = '{'{1, 0, 5'd7, 3'd1, 32'h1000_0001, 32'h1C00_003C}, 32'h80F1_7F82, 32'h0000_007F, 5'd0};

    reset = 1'b1; ex_valid = 1'b0; ex_bus = '0; wb_allow = 1'b1; rdata = '0;
    repeat (2) @(posedge clk);
    m_valid = 1'b0;

    // Reset released, nothing offered.
    drive(0, 0, idle, 1, 32'h0);
    chk("rst_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("rst_dest", 70'(MEM_dest_bus), 70'(0));
    chk("rst_allow", 70'(MEM_allow), 70'(1));
    chk("rst_load", 70'(MEM_load_bus), 70'(0));
    advance(idle);

    foreach (tbl[k]) begin
      step(0, 1, tbl[k].ins, 1, 32'h0);
      drive(0, 0, idle, 1, tbl[k].rdata);
      chk("tbl_result", 70'(MEM_to_WB_bus[63:32]), 70'(tbl[k].exp_result));
      chk("tbl_dest", 70'(MEM_dest_bus), 70'(tbl[k].exp_dest));
      chk("tbl_pc", 70'(MEM_to_WB_bus[31:0]), 70'(tbl[k].ins.pc));
      if (k == 0) chk("alu_bus", MEM_to_WB_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0010});
`ifdef MEM_FWD_EN
      chk("tbl_loadbus", 70'(MEM_load_bus), 70'(tbl[k].ins.rfm));
`else
      chk("tbl_value0", 70'(MEM_value_bus), 70'(0));
`endif
      advance(idle);
    end

    // Back-pressure: A held for 3 cycles while B is offered.
    a = '{0, 1, 5'd12, 3'd0, 32'hA5A5_0001, 32'h1C00_0100};
    b = '{0, 1, 5'd13, 3'd0, 32'h5A5A_0002, 32'h1C00_0104};
    step(0, 1, a, 1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, b, 0, 32'h0);
      chk("bp_allow", 70'(MEM_allow), 70'(0));
      chk("bp_hold", MEM_to_WB_bus, {1'b1, 5'd12, 32'hA5A5_0001, 32'h1C00_0100});
      advance(b);
    end
    drive(0, 1, b, 1, 32'h0);
    chk("bp_release_pc", 70'(MEM_to_WB_bus[31:0]), 70'(32'h1C00_0100));
    advance(b);
    drive(0, 0, idle, 1, 32'h0);
    chk("bp_new_pc", 70'(MEM_to_WB_bus[31:0]), 70'(32'h1C00_0104));
    chk("bp_new_valid", 70'(MEM_to_WB_valid), 70'(1));
    advance(idle);

    // Back-to-back stream of 4 with no bubbles.
    for (int i = 0; i < 4; i++) seq[i] = '{0, 1, 5'(i + 1), 3'd0, 32'(i), 32'h1C00_0200 + 32'(4 * i)};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, seq[i], 1, 32'h0);
      if (i > 0) begin
        chk("b2b_valid", 70'(MEM_to_WB_valid), 70'(1));
        chk("b2b_pc", 70'(MEM_to_WB_bus[31:0]), 70'(32'h1C00_0200 + 32'(4 * (i - 1))));
      end
      advance(seq[i]);
    end
    drive(0, 0, idle, 1, 32'h0);
    chk("b2b_last_pc", 70'(MEM_to_WB_bus[31:0]), 70'(32'h1C00_020C));
    advance(idle);

    // Reset while an instruction is in flight drops it.
    step(0, 1, a, 1, 32'h0);
    step(1, 1, b, 1, 32'h0);
    drive(0, 0, idle, 1, 32'h0);
    chk("midrst_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("midrst_dest", 70'(MEM_dest_bus), 70'(0));
    advance(idle);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      instr_t r;
      r = rand_instr();
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), r,
           1'($urandom_range(0, 3) != 0), $urandom);
    end

    drive(0, 0, idle, 1, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
